// File: rtl/spi_slave_responder_pkg.sv
// Shared definitions for the SPI slave responder: idle byte default and FSM state type.
package spi_slave_responder_pkg;

  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/spi_slave_fifo.sv
// Single-clock synchronous FIFO with show-ahead read: q always presents the head entry.
module spi_slave_fifo #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic [AW:0]      used,
  output logic             full,
  output logic             empty
);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      used_reg;
  logic             do_wr;
  logic             do_rd;

  // A pop on an empty FIFO is ignored, so a same-cycle write into an empty FIFO is kept.
  assign do_wr = wrreq & ~full;
  assign do_rd = rdreq & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      used_reg   <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   used_reg <= used_reg + 1'b1;
        2'b01:   used_reg <= used_reg - 1'b1;
        default: used_reg <= used_reg;
      endcase
    end
  end

  assign q     = mem[rd_ptr_reg];
  assign used  = used_reg;
  assign full  = (used_reg == FULL_CNT);
  assign empty = (used_reg == '0);

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave (CPHA=0) oversampled on clk: mosi is deserialised into rx_data/rx_valid,
// miso is fed from a TX FIFO, falling back to DUMMY (and flagging underrun) when it runs dry.
module spi_slave_responder
  import spi_slave_responder_pkg::*;
#(
  parameter bit          CPOL       = 1'b0,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  DUMMY      = DUMMY_BYTE,
  localparam int         UW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          sclk,
  input  logic          n_cs,
  input  logic          mosi,
  output logic          miso,
  input  logic [7:0]    tx_data,
  input  logic          tx_wrreq,
  output logic          tx_full,
  output logic [UW-1:0] tx_used,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  output logic [7:0]    frame_len,
  output logic          frame_done,
  output logic          underrun
);
  // Bit order in the synchroniser vectors: {sclk, n_cs, mosi}.
  localparam logic [2:0] SYNC_IDLE = {CPOL, 1'b1, 1'b0};

  logic [2:0] sync0_reg, sync1_reg, hist_reg;
  logic       lead_reg, trail_reg, cs_fall_reg, cs_rise_reg;
  logic       rise, fall;

  state_t     state_reg, state_next;
  logic [7:0] shift_in_reg, shift_in_next;
  logic [7:0] shift_out_reg, shift_out_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic       byte_done_reg, byte_done_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic [7:0] frame_len_reg, frame_len_next;
  logic       frame_done_reg, frame_done_next;
  logic       underrun_reg, underrun_next;

  logic       fifo_rd;
  logic       fifo_empty;
  logic [7:0] fifo_q;
  logic [7:0] load_byte;
  logic       mosi_d;

  assign rise   = sync1_reg[2] & ~hist_reg[2];
  assign fall   = ~sync1_reg[2] & hist_reg[2];
  assign mosi_d = hist_reg[0];

  // Edge strobes are registered; hist_reg[0] holds mosi aligned with them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync0_reg   <= SYNC_IDLE;
      sync1_reg   <= SYNC_IDLE;
      hist_reg    <= SYNC_IDLE;
      lead_reg    <= 1'b0;
      trail_reg   <= 1'b0;
      cs_fall_reg <= 1'b0;
      cs_rise_reg <= 1'b0;
    end else begin
      sync0_reg   <= {sclk, n_cs, mosi};
      sync1_reg   <= sync0_reg;
      hist_reg    <= sync1_reg;
      lead_reg    <= CPOL ? fall : rise;
      trail_reg   <= CPOL ? rise : fall;
      cs_fall_reg <= ~sync1_reg[1] & hist_reg[1];
      cs_rise_reg <= sync1_reg[1] & ~hist_reg[1];
    end
  end

  spi_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .data  (tx_data),
    .wrreq (tx_wrreq),
    .rdreq (fifo_rd),
    .q     (fifo_q),
    .used  (tx_used),
    .full  (tx_full),
    .empty (fifo_empty)
  );

  assign load_byte = fifo_empty ? DUMMY : fifo_q;

  always_comb begin
    state_next      = state_reg;
    shift_in_next   = shift_in_reg;
    shift_out_next  = shift_out_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_cnt_next   = byte_cnt_reg;
    byte_done_next  = byte_done_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    frame_len_next  = frame_len_reg;
    frame_done_next = 1'b0;
    underrun_next   = underrun_reg;
    fifo_rd         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cs_fall_reg) begin
          state_next     = ACTIVE;
          bit_cnt_next   = '0;
          byte_cnt_next  = '0;
          byte_done_next = 1'b0;
          shift_out_next = load_byte;
          underrun_next  = fifo_empty;
          fifo_rd        = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise_reg) begin
          // Partial byte and any popped-but-unsent byte are dropped here.
          state_next      = IDLE;
          frame_len_next  = byte_cnt_reg;
          frame_done_next = 1'b1;
        end else if (lead_reg) begin
          shift_in_next = {shift_in_reg[6:0], mosi_d};
          bit_cnt_next  = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            rx_data_next   = {shift_in_reg[6:0], mosi_d};
            rx_valid_next  = 1'b1;
            byte_done_next = 1'b1;
            if (byte_cnt_reg != 8'hFF) begin
              byte_cnt_next = byte_cnt_reg + 8'd1;
            end
          end
        end else if (trail_reg) begin
          if (byte_done_reg) begin
            shift_out_next = load_byte;
            fifo_rd        = 1'b1;
            byte_done_next = 1'b0;
            if (fifo_empty) begin
              underrun_next = 1'b1;
            end
          end else begin
            shift_out_next = {shift_out_reg[6:0], 1'b0};
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg      <= IDLE;
      shift_in_reg   <= '0;
      shift_out_reg  <= '0;
      bit_cnt_reg    <= '0;
      byte_cnt_reg   <= '0;
      byte_done_reg  <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      frame_len_reg  <= '0;
      frame_done_reg <= 1'b0;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_in_reg   <= shift_in_next;
      shift_out_reg  <= shift_out_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_cnt_reg   <= byte_cnt_next;
      byte_done_reg  <= byte_done_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      frame_len_reg  <= frame_len_next;
      frame_done_reg <= frame_done_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign miso       = (state_reg == ACTIVE) & shift_out_reg[7];
  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign frame_len  = frame_len_reg;
  assign frame_done = frame_done_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a CPOL=0 and a CPOL=1 instance driven by the same master
// waveform (sclk inverted for CPOL=1), checked against a table and a queue-based FIFO model.
module tb_spi_slave_responder;
  localparam int DEPTH = 16;
  localparam int UW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic sclk = 1'b0;
  logic n_cs = 1'b1;
  logic mosi = 1'b0;
  logic tx_wrreq = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic [1:0]         miso, tx_full, rx_valid, frame_done, underrun;
  logic [1:0][UW-1:0] tx_used;
  logic [1:0][7:0]    rx_data, frame_len;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    spi_slave_responder #(
      .CPOL       (gi == 1),
      .FIFO_DEPTH (DEPTH),
      .DUMMY      (8'hFF)
    ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .sclk       (gi == 1 ? ~sclk : sclk),
      .n_cs       (n_cs),
      .mosi       (mosi),
      .miso       (miso[gi]),
      .tx_data    (tx_data),
      .tx_wrreq   (tx_wrreq),
      .tx_full    (tx_full[gi]),
      .tx_used    (tx_used[gi]),
      .rx_data    (rx_data[gi]),
      .rx_valid   (rx_valid[gi]),
      .frame_len  (frame_len[gi]),
      .frame_done (frame_done[gi]),
      .underrun   (underrun[gi])
    );
  end

  // Strobe monitor: logs every rx byte and counts frame_done pulses per instance.
  logic [7:0] rx_log [2][1024];
  int rx_cnt [2] = '{0, 0};
  int fd_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rx_valid[d]) begin
        rx_log[d][rx_cnt[d] % 1024] <= rx_data[d];
        rx_cnt[d] <= rx_cnt[d] + 1;
      end
      if (frame_done[d]) begin
        fd_cnt[d] <= fd_cnt[d] + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q [$];
  logic [7:0] mosi_buf [33];
  logic [7:0] miso_got [2][33];
  logic [7:0] exp_miso [33];
  logic       exp_under;
  int         exp_used;
  int         rx_base [2];
  int         fd_base [2];

  typedef struct {
    int         npre;
    logic [7:0] pre0, pre1;
    int         nbytes, pbits;
    logic [7:0] m0, m1;
    logic [7:0] e_miso0, e_miso1;
    logic       e_under;
    int         e_used;
  } vec_t;
  vec_t vecs [5];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h", name, d, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    tx_data  = v;
    tx_wrreq = 1'b1;
    tick(1);
    tx_wrreq = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(v);
    $display("push %02h model_used=%0d", v, model_q.size());
  endtask

  // Reference: the first load happens at n_cs fall, one more after each completed byte whose
  // trailing edge is seen; the final trailing edge coincides with n_cs rising and is ignored.
  task automatic model_frame(input int nbytes, input int pbits);
    int loads;
    loads = (nbytes > 0 && pbits == 0) ? nbytes : nbytes + 1;
    exp_under = 1'b0;
    for (int k = 0; k < loads; k++) begin
      if (model_q.size() != 0) begin
        exp_miso[k] = model_q.pop_front();
      end else begin
        exp_miso[k] = 8'hFF;
        exp_under   = 1'b1;
      end
    end
    exp_used = model_q.size();
  endtask

  // Master: CPHA=0, half period 4 clk; the last sclk return to idle is simultaneous with n_cs rise.
  task automatic run_frame(input string name, input int nbytes, input int pbits);
    int total;
    total = nbytes * 8 + pbits;
    for (int d = 0; d < 2; d++) begin
      rx_base[d] = rx_cnt[d];
      fd_base[d] = fd_cnt[d];
    end
    n_cs = 1'b0;
    tick(8);
    for (int b = 0; b < total; b++) begin
      mosi = mosi_buf[b / 8][7 - (b % 8)];
      tick(4);
      for (int d = 0; d < 2; d++) miso_got[d][b / 8][7 - (b % 8)] = miso[d];
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
      if (b == total - 1) n_cs = 1'b1;
    end
    n_cs = 1'b1;
    tick(12);
    $display("frame %s: %0d bytes + %0d bits, rx0=%0d rx1=%0d", name, nbytes, pbits,
             rx_cnt[0] - rx_base[0], rx_cnt[1] - rx_base[1]);
  endtask

  task automatic check_frame(input string name, input int nbytes, input int pbits);
    logic [7:0] mask;
    mask = 8'hFF << (8 - pbits);
    for (int d = 0; d < 2; d++) begin
      check({name, " rx_count"}, d, rx_cnt[d] - rx_base[d], nbytes);
      for (int k = 0; k < nbytes; k++) begin
        check({name, " rx_byte"}, d, rx_log[d][(rx_base[d] + k) % 1024], mosi_buf[k]);
        check({name, " miso_byte"}, d, miso_got[d][k], exp_miso[k]);
      end
      if (pbits > 0) check({name, " miso_part"}, d, miso_got[d][nbytes] & mask, exp_miso[nbytes] & mask);
      check({name, " frame_done_cnt"}, d, fd_cnt[d] - fd_base[d], 1);
      check({name, " frame_len"}, d, frame_len[d], nbytes);
      check({name, " underrun"}, d, underrun[d], exp_under);
      check({name, " tx_used"}, d, tx_used[d], exp_used);
      check({name, " miso_idle"}, d, miso[d], 0);
    end
  endtask

  initial begin
    vecs[0] = '{2, 8'hA5, 8'h3C, 2, 0, 8'h12, 8'h34, 8'hA5, 8'h3C, 1'b0, 0};
    vecs[1] = '{0, 8'h00, 8'h00, 1, 0, 8'hC3, 8'h00, 8'hFF, 8'h00, 1'b1, 0};
    vecs[2] = '{1, 8'h77, 8'h00, 1, 5, 8'h12, 8'h34, 8'h77, 8'hFF, 1'b1, 0};
    vecs[3] = '{2, 8'h11, 8'h22, 0, 0, 8'h00, 8'h00, 8'h11, 8'h00, 1'b0, 1};
    vecs[4] = '{0, 8'h00, 8'h00, 1, 0, 8'h9C, 8'h00, 8'h22, 8'h00, 1'b0, 0};

    #2 n_rst = 1'b0;
    tick(3);
    n_rst = 1'b1;
    tick(6);
    for (int d = 0; d < 2; d++) begin
      check("reset miso", d, miso[d], 0);
      check("reset rx_valid", d, rx_valid[d], 0);
      check("reset rx_data", d, rx_data[d], 0);
      check("reset frame_len", d, frame_len[d], 0);
      check("reset frame_done", d, frame_done[d], 0);
      check("reset underrun", d, underrun[d], 0);
      check("reset tx_used", d, tx_used[d], 0);
      check("reset tx_full", d, tx_full[d], 0);
    end

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].npre > 0) push(vecs[i].pre0);
      if (vecs[i].npre > 1) push(vecs[i].pre1);
      mosi_buf[0] = vecs[i].m0;
      mosi_buf[1] = vecs[i].m1;
      model_frame(vecs[i].nbytes, vecs[i].pbits);
      exp_miso[0] = vecs[i].e_miso0;
      exp_miso[1] = vecs[i].e_miso1;
      exp_under   = vecs[i].e_under;
      exp_used    = vecs[i].e_used;
      run_frame($sformatf("vec%0d", i), vecs[i].nbytes, vecs[i].pbits);
      check_frame($sformatf("vec%0d", i), vecs[i].nbytes, vecs[i].pbits);
    end

    // Overflow: 17 writes into 16 entries, then drain all 16 in order.
    for (int i = 0; i < 17; i++) begin
      push(8'($urandom));
      for (int d = 0; d < 2; d++) begin
        if (i == 14) check("ovf full_at_15", d, tx_full[d], 0);
        if (i >= 15) check("ovf full", d, tx_full[d], 1);
        if (i >= 15) check("ovf used", d, tx_used[d], DEPTH);
      end
    end
    for (int k = 0; k < 16; k++) mosi_buf[k] = 8'($urandom);
    model_frame(16, 0);
    run_frame("drain16", 16, 0);
    check_frame("drain16", 16, 0);

    // Reset after 3 bits of a frame: no strobes for it, FIFO emptied.
    push(8'h81);
    push(8'h42);
    n_cs = 1'b0;
    tick(8);
    for (int b = 0; b < 3; b++) begin
      mosi = b[0];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(2);
    for (int d = 0; d < 2; d++) begin
      rx_base[d] = rx_cnt[d];
      fd_base[d] = fd_cnt[d];
    end
    n_rst = 1'b0;
    n_cs  = 1'b1;
    model_q.delete();
    tick(3);
    n_rst = 1'b1;
    tick(12);
    $display("reset mid-frame after 3 bits");
    for (int d = 0; d < 2; d++) begin
      check("rst rx_valid_cnt", d, rx_cnt[d] - rx_base[d], 0);
      check("rst frame_done_cnt", d, fd_cnt[d] - fd_base[d], 0);
      check("rst tx_used", d, tx_used[d], 0);
    end
    mosi_buf[0] = 8'h5A;
    model_frame(1, 0);
    exp_miso[0] = 8'hFF;
    exp_under   = 1'b1;
    run_frame("post_rst", 1, 0);
    check_frame("post_rst", 1, 0);

    // Randomised frames against the queue model.
    for (int r = 0; r < 30; r++) begin
      int npre;
      int nb;
      int pb;
      npre = (r % 7 == 3) ? 18 : int'($urandom_range(0, 6));
      for (int i = 0; i < npre; i++) push(8'($urandom));
      nb = $urandom_range(0, 3);
      pb = $urandom_range(0, 7);
      for (int k = 0; k <= nb; k++) mosi_buf[k] = 8'($urandom);
      model_frame(nb, pb);
      run_frame($sformatf("rnd%0d", r), nb, pb);
      check_frame($sformatf("rnd%0d", r), nb, pb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
